sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO for intra-domain buffering.
- Generalises the team's FIFO in data width, depth and thresholds.
- Adds an occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer that share one clock.
- Is the single-clock counterpart to the async FIFO and uses the same write/read handshake.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 172 +++++++++++++++++
 tb/tb_sync_fifo_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: parameter-check helpers
// and the error-kind enumeration used by the top level and its benches.
package fifo_pkg;

    localparam int MIN_DEPTH = 4;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UDF  = 2'd2
    } err_kind_e;

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; occupancy is tracked by the pointers, so
    // stale contents are never observable and the array can map onto plain storage.
    always_ff @(posedge i_clk) begin
        if (i_wren) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky
// error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  DEPTH     = 16,
    parameter int  AF_THRESH = DEPTH - 2,
    parameter int  AE_THRESH = 2,
    localparam int ADDR_W    = calc_addr_w(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_data,
    output logic              o_rd_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    generate
        if (DATA_W < 1) begin : g_bad_width
            $error("sync_fifo_param: DATA_W must be at least 1");
        end
        if (!is_pow2(DEPTH) || DEPTH < MIN_DEPTH) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
        end
        if (AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
        end
        if (AE_THRESH >= AF_THRESH) begin : g_bad_ae
            $error("sync_fifo_param: AE_THRESH must be below AF_THRESH");
        end
    endgenerate

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_LVL  = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL  = AE_THRESH[ADDR_W:0];

    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [ADDR_W:0]   count_q, count_nxt;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              full_nxt, empty_nxt, afull_nxt, aempty_nxt;
    logic              ovf_q, udf_q, ovf_nxt, udf_nxt;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] mem_rdata;

    // Accepts depend only on registered flags, so there is no pass-through path.
    assign wr_ok = i_wren && !full_q;
    assign rd_ok = i_rden && !empty_q;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_wren  (wr_ok),
        .i_waddr (wr_ptr[ADDR_W-1:0]),
        .i_wdata (i_data),
        .i_raddr (rd_ptr[ADDR_W-1:0]),
        .o_rdata (mem_rdata)
    );

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;

        if (wr_ok) wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (rd_ok) rd_ptr_nxt = rd_ptr + PTR_ONE;

        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + PTR_ONE;
            2'b01:   count_nxt = count_q - PTR_ONE;
            default: count_nxt = count_q;
        endcase

        full_nxt   = (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                     (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        afull_nxt  = (count_nxt >= AF_LVL);
        aempty_nxt = (count_nxt <= AE_LVL);
    end

    // Sticky errors: a set in the same cycle as a clear takes priority.
    always_comb begin
        ovf_nxt = ovf_q;
        udf_nxt = udf_q;

        if (i_wren && full_q) begin
            ovf_nxt = 1'b1;
        end else if (i_clr_err) begin
            ovf_nxt = 1'b0;
        end

        if (i_rden && empty_q) begin
            udf_nxt = 1'b1;
        end else if (i_clr_err) begin
            udf_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count_q  <= count_nxt;
            full_q   <= full_nxt;
            empty_q  <= empty_nxt;
            afull_q  <= afull_nxt;
            aempty_q <= aempty_nxt;
            ovf_q    <= ovf_nxt;
            udf_q    <= udf_nxt;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is presented directly; masked while empty so reset shows zero.
    assign o_data     = empty_q ? '0 : mem_rdata;
    assign o_rd_valid = !empty_q;
`else
    logic [DATA_W-1:0] rdata_q;
    logic              rd_valid_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign o_data     = rdata_q;
    assign o_rd_valid = rd_valid_q;
`endif

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations. Honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF_TH  = 14;
    localparam int AE_TH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              wren, rden, clr_err;
    logic [DATA_W-1:0] dout;
    logic              rd_valid, full, empty, afull, aempty, ovf, udf;
    logic [4:0]        count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_TH),
        .AE_THRESH (AE_TH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_data         (din),
        .i_wren         (wren),
        .i_rden         (rden),
        .i_clr_err      (clr_err),
        .o_data         (dout),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (count),
        .o_overflow     (ovf),
        .o_underflow    (udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus sticky bits and the last popped word.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_ovf, m_udf;

    always @(posedge clk) begin
        bit was_full, was_empty, acc_wr, acc_rd;
        if (rst) begin
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            acc_wr    = wren && !was_full;
            acc_rd    = rden && !was_empty;
            if (acc_rd) m_data = m_q.pop_front();
            if (acc_wr) m_q.push_back(din);
            m_valid = acc_rd;
            if (wren && was_full) m_ovf = 1'b1;
            else if (clr_err)     m_ovf = 1'b0;
            if (rden && was_empty) m_udf = 1'b1;
            else if (clr_err)      m_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count",  count,  m_q.size());
            check("m_empty",  empty,  m_q.size() == 0);
            check("m_full",   full,   m_q.size() == DEPTH);
            check("m_afull",  afull,  m_q.size() >= AF_TH);
            check("m_aempty", aempty, m_q.size() <= AE_TH);
            check("m_ovf",    ovf,    m_ovf);
            check("m_udf",    udf,    m_udf);
`ifdef SYNC_FIFO_FWFT_EN
            check("m_valid",  rd_valid, m_q.size() != 0);
            if (m_q.size() != 0) check("m_data", dout, m_q[0]);
`else
            check("m_valid",  rd_valid, m_valid);
            check("m_data",   dout,     m_data);
`endif
        end
    end

    // Apply one cycle of stimulus; returns at the following falling edge.
    task automatic step(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
        wren    = wr;
        rden    = rd;
        clr_err = clr;
        din     = d;
        @(posedge clk);
        @(negedge clk);
        wren    = 1'b0;
        rden    = 1'b0;
        clr_err = 1'b0;
    endtask

    // Check the head word before a pop in FWFT mode, or the returned word after it.
    task automatic pop_expect(input string name, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check(name, dout, exp);
        check({name, "_vld"}, rd_valid, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00);
`else
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check(name, dout, exp);
        check({name, "_vld"}, rd_valid, 1'b1);
`endif
    endtask

    initial begin
        err_kind_e seen;
        rst = 1'b1; wren = 1'b0; rden = 1'b0; clr_err = 1'b0; din = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;

        // Reset and idle
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty",  empty,    1);
        check("rst_aempty", aempty,   1);
        check("rst_count",  count,    0);
        check("rst_valid",  rd_valid, 0);
        check("rst_ovf",    ovf,      0);
        check("rst_udf",    udf,      0);

        // Fill to full with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
            check("fill_count", count, i + 1);
            check("fill_afull", afull, (i + 1) >= 14);
        end
        check("fill_full", full, 1);

        // Overflow at full, then clear
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        check("ovf_set",   ovf,   1);
        check("ovf_count", count, 16);
        step(1'b0, 0, 1'b1, 8'h00);
        check("ovf_clr",   ovf,   0);

        // Read+write at full: read wins, write rejected
`ifdef SYNC_FIFO_FWFT_EN
        check("full_rw_head", dout, 8'h00);
`endif
        step(1'b1, 1'b1, 1'b0, 8'hBB);
        check("full_rw_count", count, 15);
        check("full_rw_ovf",   ovf,   1);
`ifndef SYNC_FIFO_FWFT_EN
        check("full_rw_data",  dout,  8'h00);
`endif
        step(1'b0, 1'b0, 1'b1, 8'h00);

        for (int i = 1; i < 16; i++) pop_expect("drain_data", 8'(i));
        check("drain_empty", empty, 1);

        // Read+write on empty: write accepted, underflow flagged
        step(1'b1, 1'b1, 1'b0, 8'h55);
        check("empty_rw_count", count, 1);
        check("empty_rw_udf",   udf,   1);
        seen = ovf ? ERR_OVF : (udf ? ERR_UDF : ERR_NONE);
        check("empty_rw_kind", seen, ERR_UDF);
        pop_expect("empty_rw_data", 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("udf_clr", udf, 0);

        // Steady state at count 8 with wrapping pointers
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int k = 0; k < 40; k++) begin
            logic [7:0] exp_d;
            exp_d = (k < 8) ? 8'(8'h40 + k) : 8'(8'h80 + k - 8);
`ifdef SYNC_FIFO_FWFT_EN
            check("steady_head", dout, exp_d);
`endif
            step(1'b1, 1'b1, 1'b0, 8'(8'h80 + k));
            check("steady_count", count, 8);
`ifndef SYNC_FIFO_FWFT_EN
            check("steady_data", dout, exp_d);
`endif
        end
        for (int i = 0; i < 8; i++) pop_expect("steady_drain", 8'(8'h80 + 32 + i));
        check("steady_err", {ovf, udf}, 2'b00);

        // Reset mid-operation
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("pre_rst_udf", udf, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        check("pre_rst_count", count, 5);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("mid_rst_count",  count,    0);
        check("mid_rst_empty",  empty,    1);
        check("mid_rst_aempty", aempty,   1);
        check("mid_rst_full",   full,     0);
        check("mid_rst_afull",  afull,    0);
        check("mid_rst_data",   dout,     0);
        check("mid_rst_valid",  rd_valid, 0);
        check("mid_rst_udf",    udf,      0);
        check("mid_rst_ovf",    ovf,      0);

        step(1'b1, 1'b0, 1'b0, 8'h33);
        pop_expect("post_rst_data", 8'h33);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("post_rst_idle_valid", rd_valid, 0);
        check("post_rst_empty",      empty,    1);

        repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
